// File: rtl/rect_request_feeder_pkg.sv
// Shared types and defaults for the rectangle request feeder.
// Request bundle layout and the dimension legality helper.
package rect_request_feeder_pkg;

    localparam int DEPTH_C       = 8;
    localparam int SLOT_CYCLES_C = 4;
    localparam int MIN_DIM_C     = 4;
    localparam int MAX_DIM_C     = 16;
    localparam int DIM_W         = 5;

    typedef struct packed {
        logic [DIM_W-1:0] width;
        logic [DIM_W-1:0] height;
    } rect_req_t;

    function automatic logic dim_ok(
        input logic [DIM_W-1:0] d,
        input int               lo,
        input int               hi
    );
        return (int'(d) >= lo) && (int'(d) <= hi);
    endfunction

endpackage

// File: rtl/rect_request_feeder_if.sv
// Request-side valid/ready handshake bundle.
// Master drives a request; slave answers with ready.
interface rect_request_feeder_if;
    import rect_request_feeder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DIM_W-1:0] in_width;
    logic [DIM_W-1:0] in_height;

    modport master (
        output in_valid,
        output in_width,
        output in_height,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_width,
        input  in_height,
        output in_ready
    );

endinterface

// File: rtl/rect_request_feeder_fifo.sv
// Request FIFO: async active-high reset, no bypass path.
// Extra pointer bit distinguishes full from empty.
module rect_fifo
    import rect_request_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_C
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  rect_req_t              din_i,
    output rect_req_t              dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    rect_req_t     mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   wptr_d;
    logic [AW:0]   rptr_q;
    logic [AW:0]   rptr_d;
    logic          do_push;
    logic          do_pop;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/rect_request_feeder.sv
// Feeds one buffered rectangle request per placement slot,
// held stable for the slot; filters illegal sizes and counts.
module rect_request_feeder
    import rect_request_feeder_pkg::*;
#(
    parameter int DEPTH       = DEPTH_C,
    parameter int SLOT_CYCLES = SLOT_CYCLES_C,
    parameter int MIN_DIM     = MIN_DIM_C,
    parameter int MAX_DIM     = MAX_DIM_C
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    rect_request_feeder_if.slave   req_if,
    output logic [DIM_W-1:0]       width_o,
    output logic [DIM_W-1:0]       height_o,
    output logic                   valid_o,
    output logic                   slot_start_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [7:0]             drop_cnt_o,
    output logic [15:0]            issued_cnt_o
);

    localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(SLOT_CYCLES - 1);

    logic [PW-1:0]    ph_q;
    logic [PW-1:0]    ph_d;
    rect_req_t        out_q;
    rect_req_t        out_d;
    logic             valid_q;
    logic             valid_d;
    logic [7:0]       drop_q;
    logic [7:0]       drop_d;
    logic [15:0]      issued_q;
    logic [15:0]      issued_d;

    rect_req_t        head;
    rect_req_t        din;
    logic             full;
    logic             empty;
    logic             hs;
    logic             legal;
    logic             push;
    logic             pop;
    logic             last;

    assign din.width  = req_if.in_width;
    assign din.height = req_if.in_height;

    assign req_if.in_ready = !full;
    assign hs    = req_if.in_valid && !full;
    assign legal = dim_ok(req_if.in_width, MIN_DIM, MAX_DIM)
                && dim_ok(req_if.in_height, MIN_DIM, MAX_DIM);
    assign push  = hs && legal;
    assign last  = (ph_q == PH_LAST);
    // Pop decision uses registered empty: a same-cycle push waits a slot.
    assign pop   = last && enable_i && !empty;

    rect_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (din),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty),
        .level_o(level_o)
    );

    always_comb begin
        ph_d     = last ? '0 : ph_q + 1'b1;
        out_d    = out_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        issued_d = issued_q;
        if (last) begin
            out_d   = pop ? head : '0;
            valid_d = pop;
        end
        if (pop) begin
            issued_d = issued_q + 16'd1;
        end
        if (hs && !legal && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph_q     <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            drop_q   <= '0;
            issued_q <= '0;
        end else begin
            ph_q     <= ph_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            issued_q <= issued_d;
        end
    end

    assign width_o      = out_q.width;
    assign height_o     = out_q.height;
    assign valid_o      = valid_q;
    assign slot_start_o = (ph_q == '0);
    assign drop_cnt_o   = drop_q;
    assign issued_cnt_o = issued_q;

endmodule
